// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg_scan_pkg - scan states, register map and hex-to-7-segment decoder
// Rev 1.0
// ----------------------------------------------------------------------------
package seg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } scan_state_e;

  localparam logic [2:0] ADDR_CTRL      = 3'd6;
  localparam logic [2:0] ADDR_STATUS    = 3'd7;
  // Digit registers share the 3-bit map with CTRL/STATUS, so only 0..5 are reachable.
  localparam int         MAX_DIGIT_REGS = 6;
  localparam logic [6:0] SEG_DARK       = 7'h7F;

  // Active-low segments, bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg7_decode(input logic [3:0] code);
    case (code)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_regs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg_scan_regs - Avalon-MM register file (DIGITn, CTRL, STATUS) with zero-wait read mux
// Rev 1.0
// ----------------------------------------------------------------------------
module seg_scan_regs
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 6
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [2:0]                 address,
  input  logic                       chipselect,
  input  logic                       write_n,
  input  logic [31:0]                writedata,
  input  logic [5:0]                 status,
  output logic [31:0]                readdata,
  output logic [NUM_DIGITS-1:0][4:0] digits,
  output logic                       enable,
  output logic [7:0]                 blink_mask
);

  logic [NUM_DIGITS-1:0][4:0] digit_q, digit_d;
  logic                       enable_q, enable_d;
  logic [7:0]                 mask_q, mask_d;
  logic                       wr_en;
  logic                       unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^{writedata[31:16], writedata[7:5]};

  always_comb begin
    digit_d  = digit_q;
    enable_d = enable_q;
    mask_d   = mask_q;
    if (wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (i < MAX_DIGIT_REGS && address == 3'(i)) digit_d[i] = writedata[4:0];
      end
      if (address == ADDR_CTRL) begin
        enable_d = writedata[0];
        mask_d   = writedata[15:8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_q  <= {NUM_DIGITS{5'h10}};
      enable_q <= 1'b0;
      mask_q   <= 8'h00;
    end else begin
      digit_q  <= digit_d;
      enable_q <= enable_d;
      mask_q   <= mask_d;
    end
  end

  always_comb begin
    readdata = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i < MAX_DIGIT_REGS && address == 3'(i)) readdata[4:0] = digit_q[i];
    end
    if (address == ADDR_CTRL)        readdata[15:0] = {mask_q, 7'b0, enable_q};
    else if (address == ADDR_STATUS) readdata[5:0]  = status;
  end

  assign digits     = digit_q;
  assign enable     = enable_q;
  assign blink_mask = mask_q;

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg_scan_ctrl - multiplexed 7-segment scanner with inter-digit dark gap
// Build option: SEG_SCAN_BLINK_EN adds per-digit blinking driven by CTRL[15:8]
// Rev 1.0
// ----------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int PRESCALE     = 50000,
  parameter int GAP_CYCLES   = 500,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [6:0]            seg_n,
  output logic [NUM_DIGITS-1:0] dig_en
);

  localparam int              PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

  scan_state_e               state_q, state_d;
  logic [2:0]                idx_q, idx_d;
  logic [PRE_W-1:0]          presc_q, presc_d;
  logic [GAP_W-1:0]          gap_q, gap_d;
  logic [6:0]                seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0]     dig_en_q, dig_en_d;
  logic [NUM_DIGITS-1:0][4:0] digits;
  logic [4:0]                cur_digit;
  logic                      enable;
  logic [7:0]                blink_mask;
  logic                      blink_phase;
  logic                      blink_dark;
  logic [5:0]                status;

  assign status = {state_q, blink_phase, idx_q};

  seg_scan_regs #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_regs (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .status     (status),
    .readdata   (readdata),
    .digits     (digits),
    .enable     (enable),
    .blink_mask (blink_mask)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      presc_q  <= '0;
      gap_q    <= '0;
      seg_n_q  <= SEG_DARK;
      dig_en_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      presc_q  <= presc_d;
      gap_q    <= gap_d;
      seg_n_q  <= seg_n_d;
      dig_en_q <= dig_en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    presc_d = presc_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        idx_d   = '0;
        presc_d = '0;
        gap_d   = '0;
        if (enable) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (presc_q == PRE_LAST) begin
          presc_d = '0;
          state_d = ST_GAP;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_SHOW;
          idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Disable wins from any state.
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      presc_d = '0;
      gap_d   = '0;
    end
  end

  // Outputs are registered from the current state, and go dark together with the IDLE transition.
  always_comb begin
    seg_n_d   = SEG_DARK;
    dig_en_d  = '0;
    cur_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) cur_digit = digits[i];
    end
    if (enable && state_q == ST_SHOW) begin
      for (int i = 0; i < NUM_DIGITS; i++) dig_en_d[i] = (idx_q == 3'(i));
      if (!cur_digit[4] && !blink_dark) seg_n_d = seg7_decode(cur_digit[3:0]);
    end
  end

  assign seg_n  = seg_n_q;
  assign dig_en = dig_en_q;

`ifdef SEG_SCAN_BLINK_EN
  localparam int               FRM_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [FRM_W-1:0] frame_q, frame_d;
  logic             blink_phase_q, blink_phase_d;
  logic             frame_wrap;

  assign frame_wrap = enable && state_q == ST_GAP && gap_q == GAP_LAST && idx_q == IDX_LAST;

  always_comb begin
    frame_d       = frame_q;
    blink_phase_d = blink_phase_q;
    if (!enable || state_q == ST_IDLE) begin
      frame_d       = '0;
      blink_phase_d = 1'b0;
    end else if (frame_wrap) begin
      if (frame_q == FRM_LAST) begin
        frame_d       = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_q       <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      frame_q       <= frame_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blink_phase = blink_phase_q;
  assign blink_dark  = blink_phase_q && blink_mask[idx_q];
`else
  logic unused_blink;

  assign blink_phase  = 1'b0;
  assign blink_dark   = 1'b0;
  assign unused_blink = ^blink_mask ^ (BLINK_FRAMES > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// tb_seg_scan_ctrl - scoreboard bench: reset, scan timing, decode, blank, disable, async reset, blink.
module tb_seg_scan_ctrl;

  localparam int NUM_DIGITS   = 6;
  localparam int PRESCALE     = 4;
  localparam int GAP_CYCLES   = 2;
  localparam int BLINK_FRAMES = 2;
`ifdef SEG_SCAN_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [6:0]  seg_n;
  logic [5:0]  dig_en;

  seg_scan_ctrl #(
    .NUM_DIGITS   (NUM_DIGITS),
    .PRESCALE     (PRESCALE),
    .GAP_CYCLES   (GAP_CYCLES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .seg_n      (seg_n),
    .dig_en     (dig_en)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] name;
    logic [15:0]  tag;
    logic         chk_disp;
    logic [6:0]   seg;
    logic [5:0]   en;
    logic         chk_rd;
    logic [31:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Hand-written active-low glyphs, bit0 = a.
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [12:0] DARK  = {7'h7F, 6'd0};
  localparam int          FRAME = 36;

  logic [4:0] code_m [6];
  logic [7:0] mask_m;

  // Cycle n counts from the edge that captured CTRL.enable=1.
  function automatic logic [5:0] st_model(input int n);
    int         q;
    logic [1:0] st;
    logic       ph;
    if (n < 1) return 6'd0;
    q  = (n - 1) % FRAME;
    st = ((q % 6) < 4) ? 2'd1 : 2'd2;
    ph = BLINK && ((((n - 1) / 72) % 2) == 1);
    return {st, ph, 3'(q / 6)};
  endfunction

  function automatic logic [12:0] disp_model(input int n);
    int m, q, d;
    if (n < 2) return DARK;
    m = n - 1;
    q = (m - 1) % FRAME;
    d = q / 6;
    if ((q % 6) >= 4) return DARK;
    if (code_m[d][4] || (BLINK && ((((m - 1) / 72) % 2) == 1) && mask_m[d]))
      return {7'h7F, 6'(1 << d)};
    return {GLYPH[code_m[d][3:0]], 6'(1 << d)};
  endfunction

  // Monitor: one scoreboard entry per sampled cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk_disp) begin
        n_cmp++;
        if (seg_n !== e.seg || dig_en !== e.en) begin
          n_bad++;
          $display("FAIL %0s@%0d: seg_n=%b dig_en=%b, expected seg_n=%b dig_en=%b",
                   e.name, e.tag, seg_n, dig_en, e.seg, e.en);
        end
      end
      if (e.chk_rd) begin
        n_cmp++;
        if (readdata !== e.rd) begin
          n_bad++;
          $display("FAIL %0s@%0d: readdata=%h, expected %h", e.name, e.tag, readdata, e.rd);
        end
      end
    end
  end

  task automatic drive(input logic cs, input logic wr, input logic [2:0] a, input logic [31:0] wd);
    chipselect = cs;
    write_n    = ~wr;
    address    = a;
    writedata  = wd;
  endtask

  task automatic push(input logic [127:0] nm, input int tag, input logic [12:0] disp,
                      input logic cr, input logic [31:0] rd);
    exp_t e;
    e.name     = nm;
    e.tag      = 16'(tag);
    e.chk_disp = 1'b1;
    e.seg      = disp[12:6];
    e.en       = disp[5:0];
    e.chk_rd   = cr;
    e.rd       = rd;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [127:0] nm, input logic [2:0] a, input logic [31:0] d, input int n);
    drive(1'b1, 1'b1, a, d);
    push(nm, n, disp_model(n), 1'b0, 32'd0);
    tick();
    drive(1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic rd(input logic [127:0] nm, input logic [2:0] a, input logic [31:0] exp_rd,
                    input logic [12:0] disp, input int tag);
    drive(1'b1, 1'b0, a, 32'd0);
    push(nm, tag, disp, 1'b1, exp_rd);
    tick();
    drive(1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic scan(input logic [127:0] nm, input int n0, input int n1);
    for (int n = n0; n <= n1; n++) rd(nm, 3'd7, {26'd0, st_model(n)}, disp_model(n), n);
  endtask

  task automatic load_digits(input logic [127:0] nm, input logic [4:0] v0, input logic [4:0] v1,
                             input logic [4:0] v2, input logic [4:0] v3, input logic [4:0] v4,
                             input logic [4:0] v5);
    code_m[0] = v0; code_m[1] = v1; code_m[2] = v2;
    code_m[3] = v3; code_m[4] = v4; code_m[5] = v5;
    for (int d = 0; d < 6; d++) wr(nm, 3'(d), {27'd0, code_m[d]}, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    mask_m  = 8'h00;
    for (int d = 0; d < 6; d++) code_m[d] = 5'h10;
    drive(1'b0, 1'b0, 3'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rd("in_reset", 3'd7, 32'd0, DARK, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) rd("idle_status", 3'd7, 32'd0, DARK, i);
    rd("rst_digit0", 3'd0, 32'h10, DARK, 0);
    rd("rst_digit5", 3'd5, 32'h10, DARK, 0);
    rd("rst_ctrl", 3'd6, 32'd0, DARK, 0);

    // Digits 1..6, two full frames, then disable mid-SHOW of digit 2.
    load_digits("wr_digit", 5'h1, 5'h2, 5'h3, 5'h4, 5'h5, 5'h6);
    rd("rd_digit2", 3'd2, 32'h3, DARK, 0);
    wr("ctrl_on", 3'd6, 32'h1, -1);
    scan("scan", 0, 84);
    wr("ctrl_off", 3'd6, 32'h0, 85);
    scan("pre_off", 86, 86);
    for (int n = 87; n <= 90; n++) rd("off", 3'd7, 32'd0, DARK, n);

    // Other glyphs, blank digit 3, upper write bits masked; async reset mid-GAP.
    load_digits("wr_digit2", 5'h0, 5'h8, 5'hA, 5'h10, 5'hC, 5'hF);
    wr("wr_hibits", 3'd4, 32'hFFFF_FFEC, 0);
    rd("rd_hibits", 3'd4, 32'hC, DARK, 0);
    rd("rd_blank", 3'd3, 32'h10, DARK, 0);
    wr("ctrl_on2", 3'd6, 32'h1, -1);
    scan("scan_blank", 0, 40);
    reset_n = 1'b0;
    rd("rst_gap_dig0", 3'd0, 32'h10, DARK, 41);
    rd("rst_gap_ctrl", 3'd6, 32'd0, DARK, 42);
    reset_n = 1'b1;
    for (int d = 0; d < 6; d++) code_m[d] = 5'h10;
    rd("rst_gap_dig3", 3'd3, 32'h10, DARK, 43);
    rd("rst_gap_stat", 3'd7, 32'd0, DARK, 44);

    // Blink mask on digits 0 and 1 (inert in builds without blinking).
    load_digits("wr_digit3", 5'h7, 5'h9, 5'hB, 5'hD, 5'hE, 5'h2);
    mask_m = 8'h03;
    wr("ctrl_blink", 3'd6, 32'h0301, -1);
    scan("scan_blink", 0, 150);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
